shift_stage_ctrl: RTL and testbench

SHIFT_STAGE_CTRL -- requirements
Module: shift_stage_ctrl

---
 rtl/shift_stage_ctrl.sv | 105 ++++++++++
 tb/tb_shift_stage_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/shift_stage_ctrl.sv
// Sequencer for an external combinational barrel shifter: latches one request,
// holds the shifter operands for SETTLE cycles, captures the result, then hands it off.
module shift_stage_ctrl #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic [2:0] in_amt,
    output logic [7:0] sh_i,
    output logic [2:0] sh_s,
    input  logic [7:0] sh_y,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_zero,
    output logic [7:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

    state_t     state_q, state_d;
    logic [3:0] settle_q, settle_d;
    logic [7:0] sh_i_q, sh_i_d;
    logic [2:0] sh_s_q, sh_s_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_zero_q, out_zero_d;
    logic [7:0] op_count_q, op_count_d;

    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        sh_i_d     = sh_i_q;
        sh_s_d     = sh_s_q;
        out_data_d = out_data_q;
        out_zero_d = out_zero_q;
        op_count_d = op_count_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sh_i_d   = in_data;
                    sh_s_d   = in_amt;
                    settle_d = SETTLE_LD;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                settle_d = settle_q - 4'd1;
                // Last settle cycle: the shifter output has been stable long enough.
                if (settle_q == 4'd1) begin
                    out_data_d = sh_y;
                    out_zero_d = (sh_y == 8'd0);
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    op_count_d = op_count_q + 8'd1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            settle_q   <= 4'd0;
            sh_i_q     <= 8'd0;
            sh_s_q     <= 3'd0;
            out_data_q <= 8'd0;
            out_zero_q <= 1'b0;
            op_count_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            sh_i_q     <= sh_i_d;
            sh_s_q     <= sh_s_d;
            out_data_q <= out_data_d;
            out_zero_q <= out_zero_d;
            op_count_q <= op_count_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign sh_i      = sh_i_q;
    assign sh_s      = sh_s_q;
    assign out_data  = out_data_q;
    assign out_zero  = out_zero_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_shift_stage_ctrl.sv
// Directed bench for shift_stage_ctrl with a rotate-left shifter model and a result scoreboard.
module tb_shift_stage_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;

    logic       in_valid1, in_ready1, out_valid1, out_ready1, out_zero1;
    logic [7:0] in_data1, sh_i1, sh_y1, out_data1, op_count1;
    logic [2:0] in_amt1, sh_s1;

    logic       in_valid4, in_ready4, out_valid4, out_ready4, out_zero4;
    logic [7:0] in_data4, sh_i4, sh_y4, out_data4, op_count4;
    logic [2:0] in_amt4, sh_s4;
    logic       glitch4;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp_cnt1;

    function automatic logic [7:0] rotl(input logic [7:0] v, input logic [2:0] s);
        logic [15:0] t;
        t = {v, v} << s;
        return t[15:8];
    endfunction

    assign sh_y1 = rotl(sh_i1, sh_s1);
    assign sh_y4 = glitch4 ? ~rotl(sh_i4, sh_s4) : rotl(sh_i4, sh_s4);

    shift_stage_ctrl #(.SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1), .in_amt(in_amt1),
        .sh_i(sh_i1), .sh_s(sh_s1), .sh_y(sh_y1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .out_zero(out_zero1), .op_count(op_count1)
    );

    shift_stage_ctrl #(.SETTLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4), .in_amt(in_amt4),
        .sh_i(sh_i4), .sh_s(sh_s4), .sh_y(sh_y4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
        .out_zero(out_zero4), .op_count(op_count4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One SETTLE=1 transaction; hold = cycles the consumer stalls in HOLD.
    task automatic run1(input logic [7:0] d, input logic [2:0] a, input logic [7:0] expv,
                        input int hold);
        logic [7:0] e;
        chk("idle_ready", in_ready1, 1);
        in_valid1  = 1'b1;
        in_data1   = d;
        in_amt1    = a;
        out_ready1 = (hold == 0);
        exp_q.push_back(expv);
        @(negedge clk);
        in_valid1 = 1'b0;
        in_data1  = ~d;
        in_amt1   = ~a;
        chk("wait_ready", in_ready1, 0);
        chk("wait_valid", out_valid1, 0);
        chk("wait_sh_i", sh_i1, d);
        chk("wait_sh_s", sh_s1, a);
        @(negedge clk);
        chk("hold_valid", out_valid1, 1);
        chk("hold_ready", in_ready1, 0);
        chk("hold_sh_i", sh_i1, d);
        for (int i = 0; i < hold; i++) begin
            in_valid1 = 1'b1;
            in_data1  = 8'h5A + 8'(i);
            @(negedge clk);
            chk("stall_valid", out_valid1, 1);
            chk("stall_ready", in_ready1, 0);
            chk("stall_data", out_data1, expv);
            chk("stall_count", op_count1, exp_cnt1);
            chk("stall_sh_i", sh_i1, d);
        end
        in_valid1  = 1'b0;
        out_ready1 = 1'b1;
        e = exp_q.pop_front();
        chk("out_data", out_data1, e);
        chk("out_zero", out_zero1, (e == 8'd0));
        exp_cnt1 = exp_cnt1 + 8'd1;
        @(negedge clk);
        chk("done_valid", out_valid1, 0);
        chk("done_ready", in_ready1, 1);
        chk("done_count", op_count1, exp_cnt1);
        $display("txn d=%h a=%0d out=%h zero=%b count=%0d", d, a, out_data1, out_zero1, op_count1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] tbl[8];
        logic [7:0] d;
        logic [2:0] a;
        tbl = '{8'h62, 8'hC4, 8'h89, 8'h13, 8'h26, 8'h4C, 8'h98, 8'h31};

        rst_n = 1'b0;
        in_valid1 = 1'b0; in_data1 = 8'h00; in_amt1 = 3'd0; out_ready1 = 1'b0;
        in_valid4 = 1'b0; in_data4 = 8'h00; in_amt4 = 3'd0; out_ready4 = 1'b0;
        glitch4 = 1'b0;
        exp_cnt1 = 8'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_ready", in_ready1, 1);
        chk("rst_valid", out_valid1, 0);
        chk("rst_sh_i", sh_i1, 0);
        chk("rst_count", op_count1, 0);
        chk("rst4_ready", in_ready4, 1);
        chk("rst4_count", op_count4, 0);

        // Single rotate by one, no backpressure.
        run1(8'h62, 3'd1, 8'hC4, 0);

        // All amounts back-to-back.
        for (int i = 0; i < 8; i++) run1(8'h62, 3'(i), tbl[i], 0);

        // Zero result.
        run1(8'h00, 3'd5, 8'h00, 0);

        // Consumer stalls for 10 cycles while new requests are offered.
        run1(8'h62, 3'd3, 8'h13, 10);

        // Reset in WAIT abandons the transaction.
        chk("rw_ready", in_ready1, 1);
        in_valid1 = 1'b1; in_data1 = 8'h77; in_amt1 = 3'd2; out_ready1 = 1'b1;
        exp_q.push_back(rotl(8'h77, 3'd2));
        @(negedge clk);
        chk("rw_wait", in_ready1, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        in_valid1 = 1'b0;
        void'(exp_q.pop_back());
        exp_cnt1 = 8'd0;
        chk("rw_ready_after", in_ready1, 1);
        chk("rw_valid_after", out_valid1, 0);
        chk("rw_sh_i", sh_i1, 0);
        chk("rw_sh_s", sh_s1, 0);
        chk("rw_out_data", out_data1, 0);
        chk("rw_out_zero", out_zero1, 0);
        chk("rw_count", op_count1, 0);
        $display("txn reset during WAIT, transaction abandoned");

        // 256 completions wrap the counter.
        for (int i = 0; i < 256; i++) begin
            d = 8'($urandom_range(0, 255));
            a = 3'($urandom_range(0, 7));
            run1(d, a, rotl(d, a), 0);
        end
        chk("wrap_count", op_count1, 0);

        // SETTLE=4: operands stable through WAIT, glitches before capture ignored.
        chk("s4_idle", in_ready4, 1);
        in_valid4 = 1'b1; in_data4 = 8'hA5; in_amt4 = 3'd3; out_ready4 = 1'b0;
        exp_q.push_back(8'h2D);
        @(negedge clk);
        in_valid4 = 1'b0; in_data4 = 8'hFF; in_amt4 = 3'd7;
        glitch4 = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) glitch4 = 1'b0;
            chk("s4_wait_valid", out_valid4, 0);
            chk("s4_wait_ready", in_ready4, 0);
            chk("s4_sh_i", sh_i4, 8'hA5);
            chk("s4_sh_s", sh_s4, 3'd3);
            if (k < 4) @(negedge clk);
        end
        @(negedge clk);
        chk("s4_valid", out_valid4, 1);
        chk("s4_data", out_data4, exp_q.pop_front());
        chk("s4_zero", out_zero4, 0);
        out_ready4 = 1'b1;
        @(negedge clk);
        chk("s4_done_valid", out_valid4, 0);
        chk("s4_count", op_count4, 1);
        $display("txn s4 d=a5 a=3 out=%h count=%0d", out_data4, op_count4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
